weight_accumulator: RTL and testbench
=====================================

WEIGHT_ACCUMULATOR -- requirements
Module: weight_accumulator

Interface
REQ-001 Parameter MAX_EVENTS, default 255: maximum accepted weight events per timestep (1..255).
REQ-002 Parameter CNT_W, default 8: width of event_count.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 CLK  in  1  rising-edge clock for all state.
REQ-005 RESET_N  in  1  asynchronous active-low reset.
REQ-006 timestep_start  in  1  single-cycle pulse; clears accumulator and opens a timestep.
REQ-007 timestep_end  in  1  single-cycle pulse; closes the timestep and presents the sum.
REQ-008 weight_in  in  32  IEEE-754 single-precision synaptic weight of one incoming spike.
REQ-009 weight_valid  in  1  weight_in is valid this cycle.
REQ-010 weight_ready  out  1  block accepts weight_in this cycle.
REQ-011 input_weight  out  32  accumulated IEEE-754 weight, drives the potential adder's input_weight port.
REQ-012 weight_out_valid  out  1  input_weight is final for the closed timestep.
REQ-013 weight_out_ack  in  1  downstream adder has consumed input_weight (adder done).
REQ-014 event_count  out  CNT_W  number of events accepted this timestep.
REQ-015 exception_flag  out  1  sticky; any FP add in this timestep raised Exception.

Function
REQ-016 FSM states IDLE, ACCUM, HOLD; reset state IDLE.
REQ-017 IDLE: weight_ready=0, weight_out_valid=0; timestep_start -> ACCUM.
REQ-018 Entry to ACCUM via timestep_start: sum=32'h00000000, event_count=0, exception_flag=0 on the same edge.
REQ-019 ACCUM: weight_ready=1 unless event limit reached (REQ-025); a transfer is weight_valid && weight_ready at a rising edge.
REQ-020 On a transfer, sum <= sum + weight_in using the codebase's combinational Addition_Subtraction (operation bit 0), event_count increments; single-cycle latency, one event per cycle sustained.
REQ-021 On a transfer whose adder Exception=1, exception_flag <= 1 and remains set until the next timestep_start.
REQ-022 ACCUM with timestep_end -> HOLD; a transfer on the same edge is included in the sum.
REQ-023 HOLD: weight_ready=0, weight_out_valid=1, input_weight=sum held stable; weight_out_ack -> IDLE, weight_out_valid=0 next cycle.
REQ-024 input_weight always equals the sum register (combinational use by the adder is permitted in any state).
REQ-025 event_count==MAX_EVENTS: weight_ready=0; further events are not accepted (upstream stalls), sum unchanged.
REQ-026 timestep_start in ACCUM or HOLD: restart per REQ-018, pending sum discarded, weight_out_valid=0 next cycle; any same-cycle transfer is discarded.
REQ-027 timestep_start and timestep_end in the same cycle: timestep_start wins.
REQ-028 timestep_end in IDLE or HOLD, and weight_out_ack outside HOLD: ignored.
REQ-029 weight_in with weight_valid=0 never alters state.

Reset
REQ-030 RESET_N low asynchronously forces: state IDLE, sum/input_weight=0, weight_ready=0, weight_out_valid=0, event_count=0, exception_flag=0.
REQ-031 Reset mid-ACCUM or mid-HOLD discards the sum; release resumes in IDLE awaiting timestep_start.

Configuration
REQ-032 Macro WEIGHT_ACCUM_EVENT_LIMIT_EN defined: event_count and the MAX_EVENTS stall of REQ-025 are implemented.
REQ-033 Macro undefined: event_count tied to 0, no counter logic, weight_ready=1 throughout ACCUM regardless of event count.

Verification
REQ-034 Reset, timestep_start, weights 32'h3F800000 then 32'h40000000, timestep_end -> HOLD, input_weight=32'h40400000, event_count=2, weight_out_valid=1 until ack.
REQ-035 timestep_end coincident with transfer of 32'h42200000 after sum 32'h3F800000 -> input_weight=32'h42240000, event_count=2.
REQ-036 MAX_EVENTS=3 with macro defined, 5 back-to-back valid weights of 32'h3F800000 -> weight_ready drops after third, input_weight=32'h40400000, event_count=3; macro undefined -> 32'h40A00000, event_count=0.
REQ-037 timestep_start asserted in HOLD with sum 32'h40400000 -> weight_out_valid=0 next cycle, sum=0, state ACCUM; timestep_start+timestep_end together -> ACCUM.
REQ-038 weight 32'h7F800000 (+inf) accepted -> exception_flag=1 through HOLD, cleared by next timestep_start.
REQ-039 RESET_N pulsed low mid-ACCUM with sum 32'h40000000 -> all outputs zero immediately, IDLE after release, weight_ready=0.

Source files
------------

// File: rtl/weight_accumulator.sv
// Per-timestep IEEE-754 single-precision weight accumulator feeding the potential adder.
// Optional event counter / MAX_EVENTS stall is enabled by defining WEIGHT_ACCUM_EVENT_LIMIT_EN.
module weight_accumulator #(
    parameter int MAX_EVENTS = 255,
    parameter int CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             RESET_N,
    input  logic             timestep_start,
    input  logic             timestep_end,
    input  logic [31:0]      weight_in,
    input  logic             weight_valid,
    output logic             weight_ready,
    output logic [31:0]      input_weight,
    output logic             weight_out_valid,
    input  logic             weight_out_ack,
    output logic [CNT_W-1:0] event_count,
    output logic             exception_flag
);

    typedef enum logic [1:0] {IDLE, ACCUM, HOLD} state_t;

    state_t      state, state_next;
    logic [31:0] sum_p1;
    logic [32:0] add_res;
    logic        transfer, accept, at_limit;

    // Combinational single-precision add, round-to-nearest-even.
    // Returns {exception, result}; exception flags an inf/NaN operand or overflow.
    function automatic logic [32:0] fp_add(input logic [31:0] a, input logic [31:0] b);
        logic [31:0] x, y, res;
        logic [7:0]  ex, ey, d;
        logic [26:0] mx, my, ms;
        logic [27:0] s;
        logic [24:0] mr;
        logic [9:0]  e;
        logic        sticky, up, x_spec, y_spec, exc;
        if (a[30:0] >= b[30:0]) begin x = a; y = b; end
        else begin x = b; y = a; end
        x_spec = &x[30:23];
        y_spec = &y[30:23];
        exc    = x_spec | y_spec;
        mx = {|x[30:23], x[22:0], 3'b000};
        my = {|y[30:23], y[22:0], 3'b000};
        ex = (x[30:23] == 8'd0) ? 8'd1 : x[30:23];
        ey = (y[30:23] == 8'd0) ? 8'd1 : y[30:23];
        d  = ex - ey;
        if (d >= 8'd27) begin
            ms     = 27'd0;
            sticky = |my;
        end else begin
            ms     = my >> d;
            sticky = |(my & ~(27'h7FFFFFF << d));
        end
        ms[0] = ms[0] | sticky;
        e = {2'b00, ex};
        if (x[31] == y[31]) s = {1'b0, mx} + {1'b0, ms};
        else                s = {1'b0, mx} - {1'b0, ms};
        if (s[27]) begin
            s = {1'b0, s[27:2], s[1] | s[0]};
            e = e + 10'd1;
        end else begin
            for (int i = 0; i < 26; i++) begin
                if (!s[26] && e > 10'd1) begin
                    s = s << 1;
                    e = e - 10'd1;
                end
            end
            if (!s[26]) e = 10'd0;
        end
        up = s[2] & (s[1] | s[0] | s[3]);
        mr = {1'b0, s[26:3]} + {24'd0, up};
        if (mr[24]) begin
            mr = mr >> 1;
            e  = e + 10'd1;
        end
        if (e == 10'd0 && mr[23]) e = 10'd1;
        if (x_spec) begin
            if ((|x[22:0]) || (y_spec && x[31] != y[31])) res = 32'h7FC00000;
            else                                          res = x;
        end else if (e >= 10'd255) begin
            res = {x[31], 8'hFF, 23'd0};
            exc = 1'b1;
        end else if (e == 10'd0 && mr == 25'd0) begin
            res = {x[31] & y[31], 31'd0};
        end else begin
            res = {x[31], e[7:0], mr[22:0]};
        end
        return {exc, res};
    endfunction

    assign add_res      = fp_add(sum_p1, weight_in);
    assign input_weight = sum_p1;
    assign transfer     = weight_valid & weight_ready;
    // A start pulse in any state discards whatever transfer coincides with it.
    assign accept       = transfer & ~timestep_start;

`ifdef WEIGHT_ACCUM_EVENT_LIMIT_EN
    logic [CNT_W-1:0] cnt_p1;
    assign at_limit    = (cnt_p1 == CNT_W'(MAX_EVENTS));
    assign event_count = cnt_p1;

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N)            cnt_p1 <= '0;
        else if (timestep_start) cnt_p1 <= '0;
        else if (accept)         cnt_p1 <= cnt_p1 + 1'b1;
    end
`else
    assign at_limit    = 1'b0;
    assign event_count = '0;
`endif

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) state <= IDLE;
        else          state <= state_next;
    end

    always_comb begin
        state_next       = state;
        weight_ready     = 1'b0;
        weight_out_valid = 1'b0;
        case (state)
            IDLE: begin
                if (timestep_start) state_next = ACCUM;
            end
            ACCUM: begin
                weight_ready = ~at_limit;
                if (timestep_end) state_next = HOLD;
            end
            HOLD: begin
                weight_out_valid = 1'b1;
                if (weight_out_ack) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        if (timestep_start) state_next = ACCUM;
    end

    // Accumulator stage: sum and sticky exception update on accepted events
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            sum_p1         <= 32'h0;
            exception_flag <= 1'b0;
        end else if (timestep_start) begin
            sum_p1         <= 32'h0;
            exception_flag <= 1'b0;
        end else if (accept) begin
            sum_p1 <= add_res[31:0];
            if (add_res[32]) exception_flag <= 1'b1;
        end
    end

endmodule

// File: tb/tb_weight_accumulator.sv
// Randomized and directed bench for weight_accumulator against a real-valued timestep model.
module tb_weight_accumulator;

    localparam int MAXE  = 3;
    localparam int CNT_W = 8;
`ifdef WEIGHT_ACCUM_EVENT_LIMIT_EN
    localparam bit LIM = 1'b1;
`else
    localparam bit LIM = 1'b0;
`endif

    logic             CLK = 1'b0;
    logic             RESET_N;
    logic             timestep_start, timestep_end, weight_valid, weight_out_ack;
    logic [31:0]      weight_in;
    logic             weight_ready, weight_out_valid, exception_flag;
    logic [31:0]      input_weight;
    logic [CNT_W-1:0] event_count;

    weight_accumulator #(.MAX_EVENTS(MAXE), .CNT_W(CNT_W)) dut (
        .CLK(CLK), .RESET_N(RESET_N),
        .timestep_start(timestep_start), .timestep_end(timestep_end),
        .weight_in(weight_in), .weight_valid(weight_valid), .weight_ready(weight_ready),
        .input_weight(input_weight), .weight_out_valid(weight_out_valid),
        .weight_out_ack(weight_out_ack), .event_count(event_count),
        .exception_flag(exception_flag)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // Model: 0 = no timestep open, 1 = collecting, 2 = result presented
    int  m_mode;
    real m_sum;
    bit  m_inf;
    int  m_cnt;
    bit  m_exc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic real f32_to_real(input logic [31:0] b);
        real m;
        int  e;
        if (b[30:23] == 8'd0) return 0.0;
        m = 1.0 + real'(b[22:0]) / 8388608.0;
        e = int'(b[30:23]) - 127;
        while (e > 0) begin m = m * 2.0; e--; end
        while (e < 0) begin m = m / 2.0; e++; end
        return b[31] ? -m : m;
    endfunction

    function automatic logic [31:0] real_to_f32(input real v);
        real         m;
        int          e;
        logic        s;
        logic [22:0] f;
        if (v == 0.0) return 32'h0;
        s = (v < 0.0);
        m = s ? -v : v;
        e = 0;
        while (m >= 2.0) begin m = m / 2.0; e++; end
        while (m < 1.0)  begin m = m * 2.0; e--; end
        f = 23'($rtoi((m - 1.0) * 8388608.0));
        return {s, 8'(e + 127), f};
    endfunction

    function automatic bit m_ready();
        return (m_mode == 1) && (!LIM || m_cnt < MAXE);
    endfunction

    task automatic m_clear();
        m_sum = 0.0; m_inf = 1'b0; m_cnt = 0; m_exc = 1'b0;
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".input_weight"}, input_weight, m_inf ? 32'h7F800000 : real_to_f32(m_sum));
        check({tag, ".weight_ready"}, 32'(weight_ready), 32'(m_ready()));
        check({tag, ".out_valid"}, 32'(weight_out_valid), 32'(m_mode == 2));
        check({tag, ".event_count"}, 32'(event_count), LIM ? 32'(m_cnt) : 32'd0);
        check({tag, ".exception"}, 32'(exception_flag), 32'(m_exc));
    endtask

    // Drive one cycle of inputs, advance the model by the timestep rules, then compare.
    task automatic cyc(input string tag, input bit s, input bit e, input bit v,
                       input logic [31:0] w, input bit a);
        bit xfer;
        timestep_start = s; timestep_end = e; weight_valid = v; weight_in = w; weight_out_ack = a;
        xfer = v && m_ready();
        @(posedge CLK);
        if (s) begin
            m_clear();
            m_mode = 1;
        end else if (m_mode == 1) begin
            if (xfer) begin
                if (&w[30:23]) begin m_inf = 1'b1; m_exc = 1'b1; end
                else begin
                    if (m_inf) m_exc = 1'b1;
                    m_sum = m_sum + f32_to_real(w);
                end
                m_cnt++;
            end
            if (e) m_mode = 2;
        end else if (m_mode == 2 && a) begin
            m_mode = 0;
        end
        #1;
        compare_all(tag);
    endtask

    task automatic idle(input string tag);
        cyc(tag, 0, 0, 0, 32'h0, 0);
    endtask

    initial begin
        RESET_N = 1'b0;
        timestep_start = 0; timestep_end = 0; weight_valid = 0; weight_in = '0; weight_out_ack = 0;
        m_mode = 0;
        m_clear();
        #12;
        compare_all("reset");
        @(negedge CLK) RESET_N = 1'b1;
        @(posedge CLK); #1;

        // Two weights summed and held until ack
        idle("idle_ignore");
        cyc("end_in_idle", 0, 1, 1, 32'h3F800000, 1);
        cyc("start", 1, 0, 0, 32'h0, 0);
        cyc("w1", 0, 0, 1, 32'h3F800000, 0);
        cyc("w2", 0, 0, 1, 32'h40000000, 0);
        cyc("end", 0, 1, 0, 32'h0, 0);
        check("sum_1p2", input_weight, 32'h40400000);
        check("sum_1p2.valid", 32'(weight_out_valid), 32'd1);
        check("sum_1p2.count", 32'(event_count), LIM ? 32'd2 : 32'd0);
        cyc("hold_stall", 0, 1, 1, 32'h40000000, 0);
        check("hold_stable", input_weight, 32'h40400000);
        cyc("ack", 0, 0, 0, 32'h0, 1);
        check("ack.valid", 32'(weight_out_valid), 32'd0);

        // Transfer coincident with timestep_end is included
        cyc("start2", 1, 0, 0, 32'h0, 0);
        cyc("w_one", 0, 0, 1, 32'h3F800000, 0);
        cyc("w_end", 0, 1, 1, 32'h42200000, 0);
        check("sum_41", input_weight, 32'h42240000);
        check("sum_41.count", 32'(event_count), LIM ? 32'd2 : 32'd0);
        cyc("ack2", 0, 0, 0, 32'h0, 1);

        // Five back-to-back events against a limit of three
        cyc("start3", 1, 0, 0, 32'h0, 0);
        for (int i = 0; i < 5; i++) cyc("burst", 0, 0, 1, 32'h3F800000, 0);
        check("burst.ready", 32'(weight_ready), LIM ? 32'd0 : 32'd1);
        cyc("burst_end", 0, 1, 0, 32'h0, 0);
        check("burst.sum", input_weight, LIM ? 32'h40400000 : 32'h40A00000);
        check("burst.count", 32'(event_count), LIM ? 32'd3 : 32'd0);

        // Restart from HOLD, then start+end together
        cyc("start4", 1, 0, 0, 32'h0, 0);
        cyc("w_a", 0, 0, 1, 32'h3F800000, 0);
        cyc("w_b", 0, 0, 1, 32'h40000000, 0);
        cyc("end4", 0, 1, 0, 32'h0, 0);
        check("hold_sum", input_weight, 32'h40400000);
        cyc("restart_hold", 1, 0, 1, 32'h3F800000, 0);
        check("restart.valid", 32'(weight_out_valid), 32'd0);
        check("restart.sum", input_weight, 32'h0);
        check("restart.ready", 32'(weight_ready), 32'd1);
        cyc("start_end", 1, 1, 0, 32'h0, 0);
        check("start_wins.valid", 32'(weight_out_valid), 32'd0);
        check("start_wins.ready", 32'(weight_ready), 32'd1);

        // Infinity sets the sticky exception until the next start
        cyc("start5", 1, 0, 0, 32'h0, 0);
        cyc("w_inf", 0, 0, 1, 32'h7F800000, 0);
        cyc("w_fin", 0, 0, 1, 32'h3F800000, 0);
        cyc("end5", 0, 1, 0, 32'h0, 0);
        check("inf.flag", 32'(exception_flag), 32'd1);
        check("inf.sum", input_weight, 32'h7F800000);
        cyc("ack5", 0, 0, 0, 32'h0, 1);
        check("inf.flag_idle", 32'(exception_flag), 32'd1);
        cyc("start6", 1, 0, 0, 32'h0, 0);
        check("inf.cleared", 32'(exception_flag), 32'd0);

        // Asynchronous reset mid-accumulation
        cyc("w_c", 0, 0, 1, 32'h3F800000, 0);
        cyc("w_d", 0, 0, 1, 32'h3F800000, 0);
        check("pre_reset.sum", input_weight, 32'h40000000);
        RESET_N = 1'b0;
        #1;
        m_mode = 0;
        m_clear();
        compare_all("async_reset");
        check("async_reset.sum", input_weight, 32'h0);
        @(negedge CLK) RESET_N = 1'b1;
        @(posedge CLK); #1;
        cyc("post_reset", 0, 0, 1, 32'h3F800000, 0);
        check("post_reset.ready", 32'(weight_ready), 32'd0);

        // Randomized traffic with exactly representable quarter-step weights
        for (int i = 0; i < 600; i++) begin
            bit          s, e, v, a;
            logic [31:0] w;
            s = ($urandom_range(0, 99) < 6);
            e = ($urandom_range(0, 99) < 10);
            v = ($urandom_range(0, 99) < 65);
            a = ($urandom_range(0, 99) < 30);
            w = real_to_f32(real'(int'($urandom_range(0, 64)) - 32) / 4.0);
            cyc("rand", s, e, v, w, a);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
